// File: rtl/cbus_arbiter_if.sv
// -----------------------------------------------------------------------------
// cbus_pkg / cbus_arbiter_if
//
// Purpose : Cache-bus (cbus) request/response types plus the interface that
//           bundles the NUM_MASTERS request ports, their response ports and
//           the single downstream port of cbus_arbiter.
//
// Interface signals:
//   ireqs  [NUM_MASTERS]  cbus_req_t   per-master requests (masters -> arbiter)
//   oresps [NUM_MASTERS]  cbus_resp_t  per-master responses (arbiter -> masters)
//   oreq                  cbus_req_t   request toward memory / AXI bridge
//   oresp                 cbus_resp_t  response from memory / AXI bridge
//
// Modports:
//   slave  : the arbiter's view (consumes ireqs/oresp, drives oresps/oreq)
//   master : the environment's view (caches + memory side together)
// -----------------------------------------------------------------------------
package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [1:0]  size;     // log2 of bytes per beat
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;      // beats - 1
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

interface cbus_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  import cbus_pkg::*;

  cbus_req_t  ireqs  [NUM_MASTERS];
  cbus_resp_t oresps [NUM_MASTERS];
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  modport slave  (input  ireqs, input  oresp, output oresps, output oreq);
  modport master (output ireqs, output oresp, input  oresps, input  oreq);

endinterface

// File: rtl/cbus_arbiter.sv
// -----------------------------------------------------------------------------
// cbus_arbiter
//
// Purpose : Multiplexes the cbus requests of NUM_MASTERS cache masters onto the
//           single cbus port toward memory. One master is granted per
//           transaction and the grant is held until the memory side returns a
//           beat with ready && last. Responses go only to the granted master.
//
// Ports:
//   clk    in   system clock, all state on the rising edge
//   reset  in   synchronous, active-high reset
//   bus    slave modport of cbus_arbiter_if (ireqs, oresps, oreq, oresp)
//
// Parameters:
//   NUM_MASTERS  number of request ports (2..8), index 0 = highest priority
//   IDX_W        grant index width, derived
//
// Build option:
//   CBUS_ARB_RR_EN  when defined, round-robin arbitration starting at rr_ptr;
//                   otherwise fixed priority (lowest index wins) and no
//                   rr_ptr register exists.
// -----------------------------------------------------------------------------
module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter  int NUM_MASTERS = 2,
  localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
  input logic           clk,
  input logic           reset,
  cbus_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] index_q;
  logic [IDX_W-1:0] winner;
  logic             any_valid;

`ifdef CBUS_ARB_RR_EN
  logic [IDX_W-1:0] rr_ptr_q;
`endif

  // Winner selection. Scanning from the lowest-priority candidate down to the
  // highest lets the last hit overwrite earlier ones, so the loop needs no
  // break and maps to a plain priority mux.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    winner    = '0;
    any_valid = 1'b0;
`ifdef CBUS_ARB_RR_EN
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (bus.ireqs[(int'(rr_ptr_q) + i) % NUM_MASTERS].valid) begin
        winner    = IDX_W'((int'(rr_ptr_q) + i) % NUM_MASTERS);
        any_valid = 1'b1;
      end
    end
`else
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (bus.ireqs[i].valid) begin
        winner    = IDX_W'(i);
        any_valid = 1'b1;
      end
    end
`endif
  end

  // Grant FSM. The arbitration result only takes effect through index_q and
  // state_q, so a request is visible on oreq exactly one cycle after it first
  // shows up and nothing in ireqs can change the grant within a cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q  <= IDLE;
      index_q  <= '0;
`ifdef CBUS_ARB_RR_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            state_q  <= BUSY;
            index_q  <= winner;
`ifdef CBUS_ARB_RR_EN
            rr_ptr_q <= (winner == IDX_W'(NUM_MASTERS - 1)) ? '0 : winner + 1'b1;
`endif
          end
        end
        BUSY: begin
          // Only the final handshake releases the lock; requests from other
          // ports wait for the next IDLE cycle.
          if (bus.oresp.ready && bus.oresp.last) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Datapath: pure pass-through steered by the registered grant. In IDLE
  // everything is forced to zero, so a stray memory response never reaches
  // a master.
  always_comb begin
    bus.oreq = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      bus.oresps[k] = '0;
    end
    if (state_q == BUSY) begin
      bus.oreq            = bus.ireqs[index_q];
      bus.oresps[index_q] = bus.oresp;
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cbus_arbiter
//
// Directed bench for cbus_arbiter with three masters. Inputs are driven 1 ns
// after the rising edge and outputs are sampled on the falling edge.
// The grant order expected in test_rr_order follows CBUS_ARB_RR_EN.
// -----------------------------------------------------------------------------
module tb_cbus_arbiter;
  import cbus_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  cbus_arbiter_if #(.NUM_MASTERS(N)) bus ();

  cbus_arbiter #(.NUM_MASTERS(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  function automatic cbus_req_t mk_req(input logic [31:0] addr, input logic [3:0] len);
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.size     = 2'b10;
    r.addr     = addr;
    r.strobe   = 4'hf;
    r.data     = addr ^ 32'h5a5a_5a5a;
    r.len      = len;
    r.burst    = 2'b01;
    return r;
  endfunction

  function automatic logic [31:0] port_addr(input int k);
    return 32'h1000_0000 + 32'(k) * 32'h100;
  endfunction

  // 1 when every response port except 'skip' is all-zero (skip = -1: all).
  function automatic bit resps_zero(input int skip);
    bit z;
    z = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (k != skip && bus.oresps[k] !== '0) z = 1'b0;
    end
    return z;
  endfunction

  task automatic clear_inputs();
    for (int k = 0; k < N; k++) bus.ireqs[k] = '0;
    bus.oresp = '0;
  endtask

  // Next cycle must show the grant of 'port' on oreq.
  task automatic expect_grant(input int port, input logic [31:0] addr);
    tick();
    bus.oresp = '0;
    settle();
    vectors++;
    if (bus.oreq.valid !== 1'b1 || bus.oreq.addr !== addr) begin
      miscompares++;
      $display("FAIL grant_p%0d: oreq.valid=%b addr=%h, want valid=1 addr=%h",
               port, bus.oreq.valid, bus.oreq.addr, addr);
    end
  endtask

  // Runs nbeats response beats for the granted port (last on the final beat),
  // optionally raising another port's request at beat raise_at, then checks
  // the mandatory idle gap while the served port drops its request.
  task automatic serve(input int port, input int nbeats, input logic [31:0] addr,
                       input int raise_port, input int raise_at, input cbus_req_t raise_req);
    cbus_resp_t r;
    for (int b = 0; b < nbeats; b++) begin
      tick();
      r.ready = 1'b1;
      r.last  = (b == nbeats - 1);
      r.data  = 32'hd000_0000 + 32'(port) * 32'h100 + 32'(b);
      bus.oresp = r;
      if (b == raise_at) bus.ireqs[raise_port] = raise_req;
      settle();
      vectors++;
      if (bus.oresps[port] !== r || !resps_zero(port) || bus.oreq.addr !== addr) begin
        miscompares++;
        $display("FAIL beat_p%0d_b%0d: oresps=%h oreq.addr=%h others_zero=%b, want %h %h 1",
                 port, b, bus.oresps[port], bus.oreq.addr, resps_zero(port), r, addr);
      end
    end
    // Gap cycle: a non-final beat still on oresp must not be forwarded.
    tick();
    bus.oresp = '{ready: 1'b1, last: 1'b0, data: 32'hbad0_bad0};
    bus.ireqs[port] = '0;
    settle();
    vectors++;
    if (bus.oreq.valid !== 1'b0 || !resps_zero(-1)) begin
      miscompares++;
      $display("FAIL gap_p%0d: oreq.valid=%b resps_zero=%b, want 0 1",
               port, bus.oreq.valid, resps_zero(-1));
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    bus.ireqs[0] = mk_req(port_addr(0), 4'd0);
    tick();
    tick();
    settle();
    vectors++;
    if (bus.oreq !== '0 || !resps_zero(-1)) begin
      miscompares++;
      $display("FAIL reset_hold: oreq=%h resps_zero=%b, want 0 1", bus.oreq, resps_zero(-1));
    end
    tick();
    reset = 1'b0;
    clear_inputs();
    tick();
    settle();
    vectors++;
    if (bus.oreq !== '0 || !resps_zero(-1)) begin
      miscompares++;
      $display("FAIL reset_idle: oreq=%h resps_zero=%b, want 0 1", bus.oreq, resps_zero(-1));
    end
  endtask

  task automatic test_single_master();
    tick();
    bus.ireqs[1] = mk_req(32'h8000_0040, 4'd15);
    settle();
    vectors++;
    if (bus.oreq.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_latency: oreq.valid=%b, want 0", bus.oreq.valid);
    end
    expect_grant(1, 32'h8000_0040);
    serve(1, 16, 32'h8000_0040, 0, -1, '0);
  endtask

  task automatic test_contention();
    tick();
    bus.oresp    = '0;
    bus.ireqs[0] = mk_req(port_addr(0), 4'd1);
    bus.ireqs[1] = mk_req(port_addr(1), 4'd0);
    settle();
    vectors++;
    if (bus.oreq.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL contention_latency: oreq.valid=%b, want 0", bus.oreq.valid);
    end
    expect_grant(0, port_addr(0));
    serve(0, 2, port_addr(0), 0, -1, '0);   // gap checked while port 1 waits
    expect_grant(1, port_addr(1));
    serve(1, 1, port_addr(1), 0, -1, '0);
  endtask

  task automatic test_lock();
    tick();
    bus.oresp    = '0;
    bus.ireqs[1] = mk_req(port_addr(1) + 32'h40, 4'd7);
    expect_grant(1, port_addr(1) + 32'h40);
    serve(1, 8, port_addr(1) + 32'h40, 0, 3, mk_req(port_addr(0) + 32'h80, 4'd0));
    expect_grant(0, port_addr(0) + 32'h80);
    serve(0, 1, port_addr(0) + 32'h80, 0, -1, '0);
  endtask

  task automatic test_stray_response();
    tick();
    clear_inputs();
    bus.oresp = '{ready: 1'b1, last: 1'b1, data: 32'hcafe_f00d};
    settle();
    vectors++;
    if (bus.oreq !== '0 || !resps_zero(-1)) begin
      miscompares++;
      $display("FAIL stray_resp: oreq=%h resps_zero=%b, want 0 1", bus.oreq, resps_zero(-1));
    end
    tick();
    bus.oresp    = '0;
    bus.ireqs[2] = mk_req(port_addr(2), 4'd0);
    settle();
    vectors++;
    if (bus.oreq.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stray_no_state: oreq.valid=%b, want 0", bus.oreq.valid);
    end
    expect_grant(2, port_addr(2));
    serve(2, 1, port_addr(2), 0, -1, '0);
  endtask

  task automatic test_reset_mid_burst();
    cbus_resp_t r;
    tick();
    clear_inputs();
    bus.ireqs[1] = mk_req(port_addr(1) + 32'h200, 4'd15);
    expect_grant(1, port_addr(1) + 32'h200);
    for (int b = 0; b < 5; b++) begin
      tick();
      r = '{ready: 1'b1, last: 1'b0, data: 32'he000_0000 + 32'(b)};
      bus.oresp = r;
      if (b == 4) reset = 1'b1;
      settle();
      vectors++;
      if (bus.oresps[1] !== r) begin
        miscompares++;
        $display("FAIL midburst_b%0d: oresps[1]=%h, want %h", b, bus.oresps[1], r);
      end
    end
    tick();
    reset        = 1'b0;
    bus.ireqs[1] = '0;
    bus.ireqs[0] = mk_req(port_addr(0) + 32'h300, 4'd0);
    settle();
    vectors++;
    if (bus.oreq.valid !== 1'b0 || !resps_zero(-1)) begin
      miscompares++;
      $display("FAIL after_reset: oreq.valid=%b resps_zero=%b, want 0 1",
               bus.oreq.valid, resps_zero(-1));
    end
    expect_grant(0, port_addr(0) + 32'h300);
    serve(0, 1, port_addr(0) + 32'h300, 0, -1, '0);
  endtask

  task automatic test_rr_order();
    int exp_port;
    tick();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < N; k++) bus.ireqs[k] = mk_req(port_addr(k), 4'd0);
    for (int t = 0; t < 6; t++) begin
`ifdef CBUS_ARB_RR_EN
      exp_port = t % N;
`else
      exp_port = 0;
`endif
      expect_grant(exp_port, port_addr(exp_port));
      tick();
      bus.oresp = '{ready: 1'b1, last: 1'b1, data: 32'(t)};
      settle();
      vectors++;
      if (bus.oresps[exp_port].ready !== 1'b1 || !resps_zero(exp_port)) begin
        miscompares++;
        $display("FAIL order_t%0d: oresps[%0d].ready=%b others_zero=%b, want 1 1",
                 t, exp_port, bus.oresps[exp_port].ready, resps_zero(exp_port));
      end
      tick();
      bus.oresp = '0;
      settle();
      vectors++;
      if (bus.oreq.valid !== 1'b0) begin
        miscompares++;
        $display("FAIL order_gap_t%0d: oreq.valid=%b, want 0", t, bus.oreq.valid);
      end
    end
    tick();
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single_master();
    test_contention();
    test_lock();
    test_stray_response();
    test_reset_mid_burst();
    test_rr_order();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
